// File: rtl/jtdd2_sdram_sched_if.sv
// Bus bundle between the ROM clients, the read scheduler and the SDRAM
// controller read port.
//   slave  : scheduler view (consumes requests and controller responses,
//            drives slot_ok/data_out and the SDRAM request/address).
//   master : environment view (clients plus controller), the mirror image.
// Signals:
//   slot_req[3:0], slotN_addr[21:0] : client requests and slot-relative word addresses
//   slot_ok[3:0], data_out[31:0]    : one-hot completion pulse and returned word
//   sdram_req, sdram_addr[21:0]     : request to the controller, absolute address
//   sdram_ack, data_rdy, data_read  : controller accept, data strobe, data word
interface jtdd2_sdram_sched_if;
    logic [3:0]  slot_req;
    logic [21:0] slot0_addr;
    logic [21:0] slot1_addr;
    logic [21:0] slot2_addr;
    logic [21:0] slot3_addr;
    logic [3:0]  slot_ok;
    logic [31:0] data_out;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack;
    logic        data_rdy;
    logic [31:0] data_read;

    modport slave (
        input  slot_req, slot0_addr, slot1_addr, slot2_addr, slot3_addr,
        input  sdram_ack, data_rdy, data_read,
        output slot_ok, data_out, sdram_req, sdram_addr
    );

    modport master (
        output slot_req, slot0_addr, slot1_addr, slot2_addr, slot3_addr,
        output sdram_ack, data_rdy, data_read,
        input  slot_ok, data_out, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtdd2_sdram_sched.sv
// Four-slot SDRAM read scheduler for the Double Dragon II core.
// Slot 0 (video) has fixed priority and may be gated during vblank; slots
// 1..3 share the remaining bandwidth round-robin. The winner's address is
// rebased by a per-slot offset, the req/ack/data handshake is run with the
// controller, and the word is returned with a one-cycle one-hot slot_ok.
// Ports:
//   clk         : system clock
//   rst_n       : synchronous reset, active low
//   vblank      : vertical blank, masks slot 0 when SLOT0_VBL_GATE=1
//   downloading : ROM download in progress, blocks new grants
//   refresh_en  : registered, high when the controller may refresh
//   bus         : client and controller signals (slave modport)
module jtdd2_sdram_sched #(
    parameter logic [21:0] SLOT0_OFFSET   = 22'h0,
    parameter logic [21:0] SLOT1_OFFSET   = 22'h0,
    parameter logic [21:0] SLOT2_OFFSET   = 22'h0,
    parameter logic [21:0] SLOT3_OFFSET   = 22'h0,
    parameter bit          SLOT0_VBL_GATE = 1'b1,
    parameter int          TIMEOUT        = 63
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      vblank,
    input  logic                      downloading,
    output logic                      refresh_en,
    jtdd2_sdram_sched_if.slave        bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [5:0]  TO_VAL = 6'(TIMEOUT);
    localparam logic [21:0] OFFS [4] = '{SLOT0_OFFSET, SLOT1_OFFSET, SLOT2_OFFSET, SLOT3_OFFSET};

    state_t      state_reg, state_next;
    logic [1:0]  grant_reg, grant_next;
    logic [1:0]  rr_ptr_reg, rr_ptr_next;
    logic [5:0]  wdog_reg, wdog_next;
    logic        sdram_req_reg, sdram_req_next;
    logic [21:0] sdram_addr_reg, sdram_addr_next;
    logic [3:0]  slot_ok_reg, slot_ok_next;
    logic [31:0] data_out_reg, data_out_next;
    logic        refresh_en_reg, refresh_en_next;

    logic [21:0] slot_addr [4];
    logic [21:0] abs_addr  [4];
    logic [3:0]  elig;
    logic        grant_any;
    logic [1:0]  grant_idx;
    logic        rr_found;
    logic [1:0]  rr_idx;

    assign slot_addr[0] = bus.slot0_addr;
    assign slot_addr[1] = bus.slot1_addr;
    assign slot_addr[2] = bus.slot2_addr;
    assign slot_addr[3] = bus.slot3_addr;

    // Absolute SDRAM word address per slot; wraps modulo 2^22.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_abs
            assign abs_addr[gi] = slot_addr[gi] + OFFS[gi];
        end
    endgenerate

    // Eligible set: slot 0 masked in vblank when gated, everything masked
    // during a ROM download.
    always_comb begin
        elig = bus.slot_req;
        if (SLOT0_VBL_GATE && vblank) begin
            elig[0] = 1'b0;
        end
        if (downloading) begin
            elig = 4'b0000;
        end
    end

    // Round-robin search over slots 1..3 starting after the last RR grant.
    always_comb begin
        int c;
        c        = 0;
        rr_found = 1'b0;
        rr_idx   = rr_ptr_reg;
        for (int k = 1; k <= 3; k++) begin
            c = int'(rr_ptr_reg) + k;
            if (c > 3) begin
                c = c - 3;
            end
            if (!rr_found && elig[c[1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = c[1:0];
            end
        end
    end

    assign grant_any = |elig;
    assign grant_idx = elig[0] ? 2'd0 : rr_idx;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (grant_any) state_next = ST_REQ;
            ST_REQ:  if (bus.sdram_ack) state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.data_rdy || wdog_reg == TO_VAL) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / datapath next values. data_rdy in REQ is deliberately ignored:
    // only the ack is honoured there.
    always_comb begin
        grant_next      = grant_reg;
        rr_ptr_next     = rr_ptr_reg;
        wdog_next       = wdog_reg;
        sdram_req_next  = sdram_req_reg;
        sdram_addr_next = sdram_addr_reg;
        slot_ok_next    = 4'b0000;
        data_out_next   = data_out_reg;
        refresh_en_next = downloading || (state_reg == ST_IDLE && !grant_any);
        case (state_reg)
            ST_IDLE: begin
                if (grant_any) begin
                    grant_next      = grant_idx;
                    sdram_addr_next = abs_addr[grant_idx];
                    sdram_req_next  = 1'b1;
                    // Slot 0 sits outside the rotation.
                    if (grant_idx != 2'd0) begin
                        rr_ptr_next = grant_idx;
                    end
                end
            end
            ST_REQ: begin
                if (bus.sdram_ack) begin
                    sdram_req_next = 1'b0;
                    wdog_next      = 6'd0;
                end
            end
            ST_WAIT: begin
                if (bus.data_rdy) begin
                    data_out_next = bus.data_read;
                    slot_ok_next  = 4'b0001 << grant_reg;
                end else if (wdog_reg != TO_VAL) begin
                    wdog_next = wdog_reg + 6'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_reg      <= 2'd0;
            rr_ptr_reg     <= 2'd3;
            wdog_reg       <= 6'd0;
            sdram_req_reg  <= 1'b0;
            sdram_addr_reg <= 22'd0;
            slot_ok_reg    <= 4'b0000;
            data_out_reg   <= 32'd0;
            refresh_en_reg <= 1'b0;
        end else begin
            grant_reg      <= grant_next;
            rr_ptr_reg     <= rr_ptr_next;
            wdog_reg       <= wdog_next;
            sdram_req_reg  <= sdram_req_next;
            sdram_addr_reg <= sdram_addr_next;
            slot_ok_reg    <= slot_ok_next;
            data_out_reg   <= data_out_next;
            refresh_en_reg <= refresh_en_next;
        end
    end

    assign bus.sdram_req  = sdram_req_reg;
    assign bus.sdram_addr = sdram_addr_reg;
    assign bus.slot_ok    = slot_ok_reg;
    assign bus.data_out   = data_out_reg;
    assign refresh_en     = refresh_en_reg;

endmodule

// File: tb/tb_jtdd2_sdram_sched.sv
module tb_jtdd2_sdram_sched;
    logic clk = 1'b0;
    logic rst_n;
    logic vblank;
    logic downloading;
    logic refresh_en;
    int   checks   = 0;
    int   failures = 0;

    jtdd2_sdram_sched_if bus();

    jtdd2_sdram_sched #(
        .SLOT0_OFFSET  (22'h200000),
        .SLOT1_OFFSET  (22'h010000),
        .SLOT2_OFFSET  (22'h020000),
        .SLOT3_OFFSET  (22'h030000),
        .SLOT0_VBL_GATE(1'b1),
        .TIMEOUT       (63)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblank     (vblank),
        .downloading(downloading),
        .refresh_en (refresh_en),
        .bus        (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n           = 1'b0;
        vblank          = 1'b0;
        downloading     = 1'b0;
        bus.slot_req    = 4'b0000;
        bus.slot0_addr  = 22'h0;
        bus.slot1_addr  = 22'h0;
        bus.slot2_addr  = 22'h0;
        bus.slot3_addr  = 22'h0;
        bus.sdram_ack   = 1'b0;
        bus.data_rdy    = 1'b0;
        bus.data_read   = 32'h0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Plays the controller for one access: waits for sdram_req, acks after
    // ack_dly cycles, returns the word data_dly cycles after the ack. Ends on
    // the negedge where slot_ok should be visible.
    task automatic serve(input int ack_dly, input int data_dly, input logic [31:0] word,
                         output logic [21:0] addr_seen, output logic req_after_ack,
                         output logic [3:0] ok_seen, output logic [31:0] dout_seen);
        int n;
        n = 0;
        addr_seen = 22'h0; req_after_ack = 1'b1; ok_seen = 4'h0; dout_seen = 32'h0;
        while (bus.sdram_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.sdram_req !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL serve_wait_req: sdram_req=%b after %0d cycles, required 1", bus.sdram_req, n);
            return;
        end
        addr_seen = bus.sdram_addr;
        repeat (ack_dly) @(negedge clk);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        req_after_ack = bus.sdram_req;
        repeat (data_dly - 1) @(negedge clk);
        bus.data_rdy  = 1'b1;
        bus.data_read = word;
        @(negedge clk);
        bus.data_rdy  = 1'b0;
        ok_seen   = bus.slot_ok;
        dout_seen = bus.data_out;
        $display("txn addr=%h ok=%b data=%h", addr_seen, ok_seen, dout_seen);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.slot_req = 4'b0000; bus.sdram_ack = 1'b0; bus.data_rdy = 1'b0;
        vblank = 1'b0; downloading = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== 22'h0 || bus.slot_ok !== 4'h0 ||
            bus.data_out !== 32'h0 || refresh_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: req=%b addr=%h ok=%b dout=%h ref=%b, required all 0",
                     bus.sdram_req, bus.sdram_addr, bus.slot_ok, bus.data_out, refresh_en);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (refresh_en !== 1'b1) begin
            failures++;
            $display("FAIL reset_idle_refresh: refresh_en=%b, required 1", refresh_en);
        end
    endtask

    task automatic test_single();
        logic [21:0] a; logic r; logic [3:0] ok; logic [31:0] d;
        do_reset();
        bus.slot1_addr = 22'h00100;
        bus.slot_req   = 4'b0010;
        @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b1) begin
            failures++;
            $display("FAIL single_req_latency: sdram_req=%b one cycle after request, required 1", bus.sdram_req);
        end
        serve(3, 5, 32'hDEADBEEF, a, r, ok, d);
        bus.slot_req = 4'b0000;
        checks++;
        if (a !== 22'h10100) begin
            failures++;
            $display("FAIL single_addr: sdram_addr=%h, required 10100", a);
        end
        checks++;
        if (r !== 1'b0) begin
            failures++;
            $display("FAIL single_req_drop: sdram_req=%b after ack, required 0", r);
        end
        checks++;
        if (ok !== 4'b0010 || d !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_data: ok=%b data=%h, required 0010 deadbeef", ok, d);
        end
        @(negedge clk);
        checks++;
        if (bus.slot_ok !== 4'b0000 || bus.data_out !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL single_pulse_width: ok=%b data=%h, required 0000 deadbeef", bus.slot_ok, bus.data_out);
        end
    endtask

    task automatic test_round_robin();
        logic [21:0] a; logic r; logic [3:0] ok; logic [31:0] d;
        logic [3:0]  exp_ok   [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0010, 4'b0100, 4'b1000};
        logic [21:0] exp_addr [6] = '{22'h010001, 22'h020002, 22'h030003, 22'h010001, 22'h020002, 22'h030003};
        do_reset();
        bus.slot1_addr = 22'h1; bus.slot2_addr = 22'h2; bus.slot3_addr = 22'h3;
        bus.slot_req   = 4'b1110;
        for (int i = 0; i < 6; i++) begin
            serve(1, 2, 32'hA0000000 + i, a, r, ok, d);
            if (i == 5) bus.slot_req = 4'b0000;
            checks++;
            if (ok !== exp_ok[i] || a !== exp_addr[i] || d !== 32'hA0000000 + i) begin
                failures++;
                $display("FAIL rr_grant_%0d: ok=%b addr=%h data=%h, required %b %h %h",
                         i, ok, a, d, exp_ok[i], exp_addr[i], 32'hA0000000 + i);
            end
        end
    endtask

    task automatic test_priority_vbl();
        logic [21:0] a; logic r; logic [3:0] ok; logic [31:0] d;
        do_reset();
        bus.slot0_addr = 22'h5; bus.slot1_addr = 22'h6;
        bus.slot_req   = 4'b0011;
        serve(0, 1, 32'h11110000, a, r, ok, d);
        bus.slot_req = 4'b0010;
        checks++;
        if (ok !== 4'b0001 || a !== 22'h200005) begin
            failures++;
            $display("FAIL prio_slot0: ok=%b addr=%h, required 0001 200005", ok, a);
        end
        serve(0, 1, 32'h11110001, a, r, ok, d);
        bus.slot_req = 4'b0000;
        checks++;
        if (ok !== 4'b0010 || a !== 22'h010006) begin
            failures++;
            $display("FAIL prio_then_slot1: ok=%b addr=%h, required 0010 010006", ok, a);
        end
        @(negedge clk);
        vblank = 1'b1;
        bus.slot_req = 4'b0011;
        serve(0, 1, 32'h11110002, a, r, ok, d);
        bus.slot_req = 4'b0001;
        checks++;
        if (ok !== 4'b0010) begin
            failures++;
            $display("FAIL vbl_gate_slot1: ok=%b, required 0010", ok);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.sdram_req !== 1'b0 || refresh_en !== 1'b1) begin
            failures++;
            $display("FAIL vbl_slot0_waits: req=%b ref=%b, required 0 1", bus.sdram_req, refresh_en);
        end
        vblank = 1'b0;
        serve(0, 1, 32'h11110003, a, r, ok, d);
        bus.slot_req = 4'b0000;
        checks++;
        if (ok !== 4'b0001) begin
            failures++;
            $display("FAIL vbl_release_slot0: ok=%b, required 0001", ok);
        end
    endtask

    task automatic test_timeout();
        logic [21:0] a; logic r; logic [3:0] ok; logic [31:0] d;
        int  n;
        logic saw_ok;
        do_reset();
        bus.slot3_addr = 22'h7;
        bus.slot_req   = 4'b1000;
        @(negedge clk);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        n = 0; saw_ok = 1'b0;
        while (bus.sdram_req !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.slot_ok !== 4'b0000) saw_ok = 1'b1;
        end
        checks++;
        if (n !== 65) begin
            failures++;
            $display("FAIL timeout_cycles: re-request after %0d cycles, required 65", n);
        end
        checks++;
        if (saw_ok !== 1'b0) begin
            failures++;
            $display("FAIL timeout_no_ok: slot_ok seen=%b, required 0", saw_ok);
        end
        checks++;
        if (bus.sdram_addr !== 22'h030007) begin
            failures++;
            $display("FAIL timeout_same_addr: addr=%h, required 030007", bus.sdram_addr);
        end
        serve(0, 3, 32'hCAFEF00D, a, r, ok, d);
        bus.slot_req = 4'b0000;
        checks++;
        if (ok !== 4'b1000 || d !== 32'hCAFEF00D) begin
            failures++;
            $display("FAIL timeout_retry_done: ok=%b data=%h, required 1000 cafef00d", ok, d);
        end
    endtask

    task automatic test_reset_mid();
        logic [21:0] a; logic r; logic [3:0] ok; logic [31:0] d;
        logic bad;
        do_reset();
        bus.slot1_addr = 22'h9; bus.slot2_addr = 22'hA;
        bus.slot_req   = 4'b0010;
        serve(0, 1, 32'h12345678, a, r, ok, d);
        bus.slot_req = 4'b0100;
        @(negedge clk);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.slot_req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        bus.data_rdy  = 1'b1;
        bus.data_read = 32'h55AA55AA;
        @(negedge clk);
        bus.data_rdy = 1'b0;
        bad = 1'b0;
        repeat (2) begin
            if (bus.sdram_req !== 1'b0 || bus.sdram_addr !== 22'h0 || bus.slot_ok !== 4'h0 ||
                bus.data_out !== 32'h0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outputs: req=%b addr=%h ok=%b dout=%h, required all 0",
                     bus.sdram_req, bus.sdram_addr, bus.slot_ok, bus.data_out);
        end
        bus.slot_req = 4'b1110;
        serve(0, 1, 32'h0BADC0DE, a, r, ok, d);
        bus.slot_req = 4'b0000;
        checks++;
        if (ok !== 4'b0010) begin
            failures++;
            $display("FAIL midreset_next_slot1: ok=%b, required 0010", ok);
        end
    endtask

    task automatic test_download();
        logic [21:0] a; logic r; logic [3:0] ok; logic [31:0] d;
        logic bad;
        do_reset();
        bus.slot0_addr = 22'h3;
        downloading  = 1'b1;
        bus.slot_req = 4'b1111;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.sdram_req !== 1'b0 || refresh_en !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad !== 1'b0) begin
            failures++;
            $display("FAIL download_block: req=%b ref=%b, required 0 1", bus.sdram_req, refresh_en);
        end
        downloading = 1'b0;
        @(negedge clk);
        serve(0, 1, 32'hFEEDFACE, a, r, ok, d);
        bus.slot_req = 4'b0000;
        checks++;
        if (ok !== 4'b0001 || a !== 22'h200003) begin
            failures++;
            $display("FAIL download_release: ok=%b addr=%h, required 0001 200003", ok, a);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vblank = 1'b0;
        downloading = 1'b0;
        bus.slot_req = 4'b0000;
        bus.slot0_addr = 22'h0; bus.slot1_addr = 22'h0;
        bus.slot2_addr = 22'h0; bus.slot3_addr = 22'h0;
        bus.sdram_ack = 1'b0; bus.data_rdy = 1'b0; bus.data_read = 32'h0;
        test_reset();
        test_single();
        test_round_robin();
        test_priority_vbl();
        test_timeout();
        test_reset_mid();
        test_download();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/jtdd2_sdram_sched.md
# jtdd2_sdram_sched

Four-slot read scheduler that shares the single SDRAM read port of the Double Dragon II core between ROM requesters (video fetch, main CPU, sub/MCU, sound/ADPCM). It arbitrates pending requests, adds a per-slot base offset, runs the request/ack/data handshake with the SDRAM controller, and returns the 32-bit word to the winning slot. It sits between the game-level ROM clients and the framework SDRAM controller, and owns `refresh_en`.

## Interface
Parameters:
- `SLOT0_OFFSET`, default 22'h0: SDRAM word base added to slot 0 address.
- `SLOT1_OFFSET`, default 22'h0: base for slot 1.
- `SLOT2_OFFSET`, default 22'h0: base for slot 2.
- `SLOT3_OFFSET`, default 22'h0: base for slot 3.
- `SLOT0_VBL_GATE`, default 1: when 1, slot 0 requests are ignored while `vblank`=1.
- `TIMEOUT`, default 63: max cycles in WAIT_DATA before abort and retry; 6-bit counter.

Ports:
- `clk` in 1: system clock, 48 MHz.
- `rst_n` in 1: synchronous reset, active low.
- `vblank` in 1: vertical blank, used for slot 0 gating.
- `downloading` in 1: ROM download active; blocks all grants.
- `slot_req` in 4: per-slot request level, held until the matching `slot_ok` pulse.
- `slot0_addr` … `slot3_addr` in 22 each: word address, relative to the slot base.
- `slot_ok` out 4: one-cycle pulse, one-hot; `data_out` is valid for that slot.
- `data_out` out 32: last returned SDRAM word.
- `sdram_req` out 1: request to the SDRAM controller.
- `sdram_addr` out 22: absolute word address.
- `sdram_ack` in 1: controller accepted the request.
- `data_rdy` in 1: `data_read` is valid.
- `data_read` in 32: SDRAM read data.
- `refresh_en` out 1: controller may refresh.

## Operation
- States are IDLE, REQ, WAIT_DATA.
- **IDLE**
  - Eligible set = `slot_req` with bit 0 masked when `SLOT0_VBL_GATE`=1 and `vblank`=1. The set is empty while `downloading`=1.
  - Slot 0 has fixed highest priority.
  - Slots 1–3 are round-robin. The search starts at the slot after the last granted RR slot and wraps 3→1. The RR pointer resets to 3, so slot 1 wins first. Slot 0 grants do not move the pointer.
  - On a non-empty set: latch the grant index, load `sdram_addr` = offset + addr (mod 2^22), set `sdram_req`=1, go to REQ.
- **REQ**
  - Hold `sdram_req` and `sdram_addr` stable.
  - When `sdram_ack`=1: drop `sdram_req`, clear the watchdog, go to WAIT_DATA.
- **WAIT_DATA**
  - The watchdog increments each cycle.
  - On `data_rdy`=1: latch `data_out`=`data_read`, pulse the granted `slot_ok` bit, go to IDLE.
  - On watchdog = `TIMEOUT` without `data_rdy`: go to IDLE with no `slot_ok`. The request is still pending and is re-arbitrated normally.
- A requester that drops `slot_req` before its `slot_ok` does not cancel an in-flight access. The word is still returned with `slot_ok`.
- `refresh_en` = 1 only in IDLE with an empty eligible set. It is also 1 while `downloading`=1.
- `downloading` rising mid-access does not abort the access; it only blocks new grants.

## Timing
- Reset (`rst_n`=0 sampled at a rising edge) puts these outputs on the next edge:
  - `sdram_req`=0, `sdram_addr`=0, `slot_ok`=0, `data_out`=0, `refresh_en`=0.
  - state = IDLE, RR pointer = 3, watchdog = 0.
- Reset mid-access discards the outstanding transfer. A late `data_rdy` after reset is ignored because state is IDLE.
- Request at IDLE edge n → `sdram_req`=1 and the address valid from edge n+1.
- `sdram_ack` sampled at edge m → `sdram_req`=0 from m+1.
- `data_rdy` sampled at edge k → `slot_ok` and `data_out` valid from k+1 for exactly one cycle.
- Back-to-back: `slot_ok` cycle k+1 is IDLE, so the next grant issues `sdram_req` at k+2. Minimum turnaround is 4 cycles plus the controller latency.
- `sdram_ack` and `data_rdy` in the same cycle while in REQ: treat as ack only. Data is taken only in WAIT_DATA.
- A requester may assert a new request in the cycle after its `slot_ok`.
- `refresh_en` is registered and follows the state and eligible set with 1-cycle latency.

## Test plan
- **Single request:** reset, `slot_req`=4'b0010, `slot1_addr`=22'h00100, `SLOT1_OFFSET`=22'h10000. Ack 3 cycles later, data 22'hxx=32'hDEADBEEF 5 cycles after ack. Required: `sdram_addr`=22'h10100, one `slot_ok`=4'b0010 pulse, `data_out`=32'hDEADBEEF.
- **Round robin:** `slot_req`=4'b1110 held, each access completed. Required grant order 1,2,3,1,2,3.
- **Priority and VBL gating:**
  - `slot_req`=4'b0011 with `vblank`=0: slot 0 granted first, RR pointer unchanged, next grant slot 1.
  - With `vblank`=1: slot 1 granted, slot 0 waits.
- **Timeout:** withhold `data_rdy` after ack. Required: after `TIMEOUT` cycles the FSM returns to IDLE, no `slot_ok`, the same slot is re-requested with the same `sdram_addr`.
- **Reset mid-access:** `rst_n`=0 during WAIT_DATA, then `data_rdy` asserted. Required: all outputs 0, no `slot_ok`, next grant goes to slot 1.
- **Download and refresh:** `downloading`=1 with `slot_req`=4'b1111. Required: `sdram_req` stays 0 and `refresh_en`=1. After `downloading` falls, slot 0 is granted (with `vblank`=0).
